maze_dfs_ctrl: RTL

//  Parametrised depth-first maze-solver controller; drives a 1-bit-per-cell maze memory and an external LIFO.

---
 rtl/maze_dfs_ctrl_if.sv | 29 ++
 rtl/maze_dfs_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/maze_dfs_ctrl_if.sv
// Maze-memory and LIFO handshake bundle between the DFS controller and its external storage.
`timescale 1ns/1ps
interface maze_dfs_ctrl_if #(
  parameter int unsigned COORD_W = 4
);
  localparam int unsigned LOC_W = 2 * COORD_W;

  logic [LOC_W-1:0]   mem_addr;
  logic               mem_rd;
  logic               mem_rvalid;
  logic               mem_rdata;
  logic               mem_wr;
  logic               stk_push;
  logic [LOC_W+1:0]   stk_wdata;
  logic               stk_pop;
  logic [LOC_W+1:0]   stk_top;
  logic               stk_empty;
  logic               stk_full;

  modport master (
    output mem_addr, mem_rd, mem_wr, stk_push, stk_wdata, stk_pop,
    input  mem_rvalid, mem_rdata, stk_top, stk_empty, stk_full
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, stk_push, stk_wdata, stk_pop,
    output mem_rvalid, mem_rdata, stk_top, stk_empty, stk_full
  );
endinterface

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver: walks a 1-bit-per-cell maze memory, keeping {dir,loc} breadcrumbs
// on an external LIFO so backtracking resumes at the next untried direction.
`timescale 1ns/1ps
module maze_dfs_ctrl #(
  parameter int unsigned             COORD_W   = 4,
  parameter logic [2*COORD_W-1:0]    START_LOC = '0,
  parameter logic [2*COORD_W-1:0]    DEST_LOC  = '1,
  parameter int unsigned             STEP_W    = 12,
  parameter int unsigned             MAX_STEPS = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  maze_dfs_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [1:0]            fail_code,
  output logic [2*COORD_W-1:0]  curr_loc,
  output logic [STEP_W-1:0]     step_cnt
);
  localparam int unsigned LOC_W = 2 * COORD_W;

  typedef enum logic [3:0] {
    StIdle, StInit, StCheck, StTry, StWait, StNext, StAdv, StBack, StDone, StFail
  } state_e;

  state_e             state_q, state_d;
  logic [LOC_W-1:0]   loc_q, loc_d;
  logic [1:0]         dir_q, dir_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [1:0]         code_q, code_d;
  // One-cycle flag: the move just taken brought step count to MAX_STEPS.
  logic               tmo_q, tmo_d;

  logic [COORD_W-1:0] cur_x, cur_y;
  logic [LOC_W-1:0]   nbr;
  logic               off_grid;
  logic [STEP_W-1:0]  step_nxt;

  always_comb begin
    cur_y    = loc_q[LOC_W-1:COORD_W];
    cur_x    = loc_q[COORD_W-1:0];
    nbr      = loc_q;
    off_grid = 1'b0;
    unique case (dir_q)
      2'd0: begin off_grid = (cur_y == '0); nbr = {cur_y - COORD_W'(1), cur_x}; end
      2'd1: begin off_grid = (cur_x == '1); nbr = {cur_y, cur_x + COORD_W'(1)}; end
      2'd2: begin off_grid = (cur_y == '1); nbr = {cur_y + COORD_W'(1), cur_x}; end
      2'd3: begin off_grid = (cur_x == '0); nbr = {cur_y, cur_x - COORD_W'(1)}; end
    endcase
  end

  assign step_nxt = step_q + STEP_W'(1);

  always_comb begin
    state_d = state_q;
    loc_d   = loc_q;
    dir_d   = dir_q;
    step_d  = step_q;
    done_d  = done_q;
    fail_d  = fail_q;
    code_d  = code_q;
    tmo_d   = 1'b0;

    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.stk_push  = 1'b0;
    bus.stk_wdata = '0;
    bus.stk_pop   = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d = StInit;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = 2'b00;
          step_d  = '0;
          loc_d   = START_LOC;
          dir_d   = 2'd0;
        end
      end
      StInit: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = loc_q;
        state_d      = StCheck;
      end
      StCheck: begin
        if (loc_q == DEST_LOC) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (tmo_q) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b11;
        end else begin
          dir_d   = 2'd0;
          state_d = StTry;
        end
      end
      StTry: begin
        if (off_grid) begin
          state_d = StNext;
        end else begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = nbr;
          state_d      = StWait;
        end
      end
      StWait: begin
        bus.mem_addr = nbr;
        if (bus.mem_rvalid) begin
          state_d = bus.mem_rdata ? StNext : StAdv;
        end
      end
      StNext: begin
        if (tmo_q) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b11;
        end else if (dir_q == 2'd3) begin
          state_d = StBack;
        end else begin
          dir_d   = dir_q + 2'd1;
          state_d = StTry;
        end
      end
      StAdv: begin
        if (bus.stk_full) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b10;
        end else begin
          bus.stk_push  = 1'b1;
          bus.stk_wdata = {dir_q, loc_q};
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = nbr;
          loc_d         = nbr;
          step_d        = step_nxt;
          tmo_d         = (step_nxt == STEP_W'(MAX_STEPS));
          state_d       = StCheck;
        end
      end
      StBack: begin
        if (bus.stk_empty) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b01;
        end else begin
          bus.stk_pop = 1'b1;
          loc_d       = bus.stk_top[LOC_W-1:0];
          dir_d       = bus.stk_top[LOC_W+1:LOC_W];
          step_d      = step_nxt;
          tmo_d       = (step_nxt == STEP_W'(MAX_STEPS));
          state_d     = StNext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      loc_q   <= START_LOC;
      dir_q   <= 2'd0;
      step_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'b00;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      loc_q   <= loc_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy      = !(state_q inside {StIdle, StDone, StFail});
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign curr_loc  = loc_q;
  assign step_cnt  = step_q;

endmodule
